// File: rtl/adxl362_pkg.sv
// Shared types and constants for the ADXL362 register-access sequencer.
package adxl362_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // SPI command bytes and the filler byte clocked out while reading
    localparam logic [7:0] DEF_CMD_WRITE = 8'h0A;
    localparam logic [7:0] DEF_CMD_READ  = 8'h0B;
    localparam logic [7:0] DEF_READ_FILL = 8'h00;

    // Frequently used ADXL362 register addresses
    localparam logic [7:0] DEVID_AD   = 8'h00;
    localparam logic [7:0] DEVID_MST  = 8'h01;
    localparam logic [7:0] PARTID     = 8'h02;
    localparam logic [7:0] REVID      = 8'h03;
    localparam logic [7:0] XDATA      = 8'h08;
    localparam logic [7:0] YDATA      = 8'h09;
    localparam logic [7:0] ZDATA      = 8'h0A;
    localparam logic [7:0] STATUS     = 8'h0B;
    localparam logic [7:0] SOFT_RESET = 8'h1F;
    localparam logic [7:0] FILTER_CTL = 8'h2C;
    localparam logic [7:0] POWER_CTL  = 8'h2D;

    // Index of the final byte (data phase) in a register transaction
    localparam logic [1:0] LAST_BYTE = 2'd2;

endpackage

// File: rtl/adxl362_controller.sv
// Sequences one ADXL362 register read/write into three spi_controller bytes:
// command, address, data.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; request fields latched on acceptance
// ST_ISSUE | waiting for the byte engine to be free, then strobes spi_start
// ST_WAIT  | byte in flight; waits for spi_done, advances byte_idx
// ST_FIN   | one-cycle done pulse, then back to idle
module adxl362_controller
    import adxl362_pkg::*;
#(
    parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE,
    parameter logic [7:0] CMD_READ  = DEF_CMD_READ,
    parameter logic [7:0] READ_FILL = DEF_READ_FILL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       write,
    input  logic [7:0] address,
    input  logic [7:0] data_to_send,
    output logic [7:0] data_received,
    output logic       busy,
    output logic       done,
    output logic       spi_start,
    output logic [7:0] spi_data_to_send,
    output logic       spi_hold_cs,
    input  logic       spi_busy,
    input  logic       spi_done,
    input  logic [7:0] spi_data_received
);

    state_e     state_q, state_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic       write_q, write_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] spi_byte_q, spi_byte_d;
    logic       hold_q, hold_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= 2'd0;
            write_q    <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            spi_byte_q <= 8'h00;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            spi_byte_q <= spi_byte_d;
            hold_q     <= hold_d;
        end
    end

    // Next-state logic; the outgoing byte and hold_cs are loaded on each
    // ISSUE entry so they stay stable for the whole byte.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        spi_byte_d = spi_byte_q;
        hold_d     = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ISSUE;
                    byte_idx_d = 2'd0;
                    write_d    = write;
                    addr_d     = address;
                    wdata_d    = data_to_send;
                    spi_byte_d = write ? CMD_WRITE : CMD_READ;
                    hold_d     = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!spi_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (spi_done) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = ST_FIN;
                        if (!write_q) begin
                            rdata_d = spi_data_received;
                        end
                    end else begin
                        state_d    = ST_ISSUE;
                        byte_idx_d = byte_idx_q + 2'd1;
                        hold_d     = (byte_idx_q + 2'd1) != LAST_BYTE;
                        if (byte_idx_q == 2'd0) begin
                            spi_byte_d = addr_q;
                        end else begin
                            spi_byte_d = write_q ? wdata_q : READ_FILL;
                        end
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign spi_start        = (state_q == ST_ISSUE) && !spi_busy;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_FIN);
    assign spi_data_to_send = spi_byte_q;
    assign spi_hold_cs      = hold_q;
    assign data_received    = rdata_q;

endmodule

// File: tb/tb_adxl362_controller.sv
// Bench for adxl362_controller: a behavioural SPI byte engine (mode 0,
// SCLK = clk/2) plus an ADXL362-like subunit that records MOSI bytes and
// returns 8'hAD on MISO.
module tb_adxl362_controller;
    import adxl362_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       write = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] data_to_send = 8'h00;
    logic [7:0] data_received;
    logic       busy;
    logic       done;
    logic       spi_start;
    logic [7:0] spi_data_to_send;
    logic       spi_hold_cs;
    logic       spi_busy = 1'b0;
    logic       spi_done = 1'b0;
    logic [7:0] spi_data_received;

    int vectors = 0;
    int miscompares = 0;

    adxl362_controller dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .write            (write),
        .address          (address),
        .data_to_send     (data_to_send),
        .data_received    (data_received),
        .busy             (busy),
        .done             (done),
        .spi_start        (spi_start),
        .spi_data_to_send (spi_data_to_send),
        .spi_hold_cs      (spi_hold_cs),
        .spi_busy         (spi_busy),
        .spi_done         (spi_done),
        .spi_data_received(spi_data_received)
    );

    always #5 clk = ~clk;

    // ---------------- SPI byte engine model ----------------
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       miso;
    logic [7:0] eng_tx = 8'h00;
    logic [7:0] eng_rx = 8'h00;
    logic       eng_hold = 1'b0;
    int         eng_ph = 0;

    assign spi_data_received = eng_rx;

    always @(posedge clk) begin
        spi_done <= 1'b0;
        if (rst) begin
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            spi_busy <= 1'b0;
            eng_ph   <= 0;
        end else if (!spi_busy) begin
            if (spi_start) begin
                spi_busy <= 1'b1;
                cs_n     <= 1'b0;
                eng_tx   <= spi_data_to_send;
                eng_hold <= spi_hold_cs;
                eng_ph   <= 0;
                sclk     <= 1'b0;
            end
        end else begin
            if (eng_ph % 2 == 0) begin
                sclk   <= 1'b1;
                eng_rx <= {eng_rx[6:0], miso};
            end else begin
                sclk   <= 1'b0;
                eng_tx <= {eng_tx[6:0], 1'b0};
            end
            eng_ph <= eng_ph + 1;
            if (eng_ph == 15) begin
                spi_busy <= 1'b0;
                spi_done <= 1'b1;
                if (!eng_hold) cs_n <= 1'b1;
            end
        end
    end

    // ---------------- ADXL362 subunit model ----------------
    localparam logic [7:0] RESP = 8'hAD;
    logic [2:0] sub_bit = 3'd0;
    logic [7:0] sub_sr = 8'h00;
    logic [7:0] mosi_q[$];
    int         sclk_rises = 0;
    int         cs_rises = 0;
    int         done_cnt = 0;

    assign miso = RESP[3'd7 - sub_bit];

    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            sub_bit = 3'd0;
            cs_rises++;
        end else begin
            sub_sr = {sub_sr[6:0], eng_tx[7]};
            sclk_rises++;
            if (sub_bit == 3'd7) begin
                mosi_q.push_back(sub_sr);
                sub_bit = 3'd0;
            end else begin
                sub_bit = sub_bit + 3'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int rd_ptr = 0;
    int cs_base, sclk_base, done_base;

    // Issues one request and waits (bounded) for done. Returns in the done
    // cycle. A stray start is injected at loop cycle 'inject' (if >= 0).
    task automatic run_txn(input string tag, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input int inject);
        bit seen;
        bit prev_sd;
        int sd_cnt;
        int busy_low;
        cs_base   = cs_rises;
        sclk_base = sclk_rises;
        done_base = done_cnt;
        start = 1'b1; write = w; address = a; data_to_send = d;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        seen = 0; prev_sd = 0; sd_cnt = 0; busy_low = 0;
        for (int n = 0; n < 2000; n++) begin
            if (n == inject) begin
                start = 1'b1; address = 8'h55; write = ~w;
            end else begin
                start = 1'b0;
            end
            prev_sd = spi_done;
            if (spi_done) sd_cnt++;
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                break;
            end
            if (!busy) busy_low++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_latency"}, prev_sd, 1);
        chk({tag, "_spi_dones"}, sd_cnt, 3);
        chk({tag, "_busy_held"}, busy_low, 0);
        chk({tag, "_busy_fin"}, busy, 1);
        chk({tag, "_cs_high_fin"}, cs_n, 1);
    endtask

    // Advances one cycle past done and checks the recorded transaction.
    task automatic after_txn(input string tag, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] exp_b[3];
        exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
        @(posedge clk); #1;
        chk({tag, "_done_pulses"}, done_cnt - done_base, 1);
        chk({tag, "_cs_rises"}, cs_rises - cs_base, 1);
        chk({tag, "_sclk_edges"}, sclk_rises - sclk_base, 24);
        chk({tag, "_nbytes"}, mosi_q.size() - rd_ptr, 3);
        for (int i = 0; i < 3; i++) begin
            if (mosi_q.size() > rd_ptr + i)
                chk($sformatf("%s_byte%0d", tag, i), mosi_q[rd_ptr + i], exp_b[i]);
        end
        rd_ptr = mosi_q.size();
        chk({tag, "_idle"}, busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] ra, rd;
        int guard;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_received", data_received, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_spi_data", spi_data_to_send, 8'h00);
        chk("rst_hold_cs", spi_hold_cs, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write POWER_CTL
        run_txn("wr_pctl", 1'b1, POWER_CTL, 8'h02, -1);
        chk("wr_pctl_rdata", data_received, 8'h00);
        after_txn("wr_pctl", 8'h0A, 8'h2D, 8'h02);

        // Read DEVID_AD
        run_txn("rd_devid", 1'b0, DEVID_AD, 8'h77, -1);
        chk("rd_devid_rdata_done", data_received, 8'hAD);
        after_txn("rd_devid", 8'h0B, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        chk("rd_devid_rdata_held", data_received, 8'hAD);

        // Start while busy is ignored
        run_txn("busy_start", 1'b1, FILTER_CTL, 8'h13, 20);
        after_txn("busy_start", 8'h0A, 8'h2C, 8'h13);
        chk("busy_start_rdata", data_received, 8'hAD);

        // Start coinciding with done is ignored
        run_txn("done_start", 1'b1, 8'h20, 8'hFA, -1);
        start = 1'b1; address = 8'h55; write = 1'b0;
        after_txn("done_start", 8'h0A, 8'h20, 8'hFA);
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("done_start_no_bytes", mosi_q.size() - rd_ptr, 0);
        chk("done_start_no_busy", busy, 0);

        // Reset during byte 1
        start = 1'b1; write = 1'b1; address = POWER_CTL; data_to_send = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!spi_done && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("mid_rst_byte0_done", spi_done, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_pre_busy", busy, 1);
        chk("mid_rst_pre_hold", spi_hold_cs, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_spi_start", spi_start, 0);
        chk("mid_rst_hold_cs", spi_hold_cs, 0);
        chk("mid_rst_cs_n", cs_n, 1);
        chk("mid_rst_rdata", data_received, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        rd_ptr = mosi_q.size();
        run_txn("post_rst_rd", 1'b0, DEVID_AD, 8'h00, -1);
        chk("post_rst_rdata", data_received, 8'hAD);
        after_txn("post_rst_rd", 8'h0B, 8'h00, 8'h00);

        // Back-to-back random writes, each one cycle after done
        for (int k = 0; k < 10; k++) begin
            ra = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            run_txn($sformatf("b2b%0d", k), 1'b1, ra, rd, -1);
            after_txn($sformatf("b2b%0d", k), 8'h0A, ra, rd);
        end
        chk("b2b_rdata_kept", data_received, 8'hAD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adxl362_controller.md
Name: adxl362_controller

Overview:
Register-access sequencer directly upstream of spi_controller. It turns one register read or write request into the 3-byte ADXL362 SPI transaction: command, address, data. It drives spi_controller's start/data_to_send/hold_cs and consumes its busy/done/data_received. The top level instantiates both blocks side by side and shares clk/rst between them.

Parameters:
CMD_WRITE, 8'h0A, command byte for register write
CMD_READ, 8'h0B, command byte for register read
READ_FILL, 8'h00, byte shifted out on MOSI during the read data phase

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
write  input  1  1 = register write, 0 = register read; latched at start
address  input  8  register address; latched at start
data_to_send  input  8  write data; latched at start
data_received  output  8  read result; valid from the done pulse until the next read completes
busy  output  1  transaction in progress
done  output  1  one-cycle pulse when the transaction is complete
spi_start  output  1  one-cycle byte-start strobe to spi_controller
spi_data_to_send  output  8  byte to spi_controller
spi_hold_cs  output  1  keep CS low after the current byte
spi_busy  input  1  from spi_controller
spi_done  input  1  one-cycle byte-complete pulse from spi_controller
spi_data_received  input  8  byte shifted in on MISO; valid with spi_done

Behaviour:
- Reset values: data_received=0, busy=0, done=0, spi_start=0, spi_data_to_send=0, spi_hold_cs=0, FSM=IDLE, byte_idx=0.
- FSM states:
  - IDLE: on start, latch write/address/data_to_send, set byte_idx=0, go to ISSUE. busy rises in the next cycle.
  - ISSUE: when spi_busy=0, pulse spi_start for exactly one cycle, then go to WAIT. If spi_busy=1, stay in ISSUE.
  - WAIT: hold until spi_done. On spi_done: if byte_idx<2, increment byte_idx and go to ISSUE; if byte_idx=2, go to FIN.
  - FIN: done=1 and busy=1 for one cycle, then return to IDLE.
- Byte sequence:
  - byte 0 = CMD_WRITE or CMD_READ.
  - byte 1 = latched address.
  - byte 2 = latched data (write) or READ_FILL (read).
- spi_data_to_send holds the current byte from the ISSUE cycle through that byte's spi_done.
- spi_hold_cs=1 while byte_idx is 0 or 1 and 0 while byte_idx is 2. It changes only on the ISSUE entry for the next byte, so it is stable for each byte from start to done. This keeps CS low across all three bytes.
- Reads: on the spi_done for byte 2, capture spi_data_received into data_received. Writes leave data_received unchanged.
- busy=1 in ISSUE, WAIT and FIN.
- start is ignored while busy=1. A start in the same cycle as done is also ignored; a new request is accepted only from IDLE.
- Latency: done occurs one cycle after the third spi_done.
- Reset mid-transaction: all outputs return to reset values in the next cycle. spi_controller shares rst, so it aborts too and CS deasserts.
- A spi_done received outside WAIT is ignored.

Decomposition:
- Package adxl362_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, FIN)
  - CMD_WRITE, CMD_READ, READ_FILL defaults
  - register address constants: DEVID_AD=8'h00, POWER_CTL=8'h2D, XDATA=8'h08, etc.
- No internal sub-module. spi_controller stays a sibling instance so the byte engine can be reused unchanged.
- Bench wiring: adxl362_controller -> spi_controller -> spi_subunit model. An always_ff on posedge SPI_SCLK shifts in MOSI bytes for checking.

Test Plan:
- Write POWER_CTL: write=1, address=8'h2D, data_to_send=8'h02 -> MOSI bytes 0A, 2D, 02 in order; SPI_CS low continuously across all 24 SCLK edges; exactly one done pulse; data_received unchanged.
- Read DEVID_AD: write=0, address=8'h00, subunit returns 8'hAD -> MOSI bytes 0B, 00, 00; data_received=8'hAD at the done pulse and held afterward.
- Start while busy: a second start pulse mid-transaction with address=8'h55 -> ignored; only one 3-byte transaction is seen on MOSI; busy stays high until the single done.
- Reset mid-operation: assert rst during byte 1 -> next cycle busy=0, spi_start=0, spi_hold_cs=0, SPI_CS=1. A following read of 8'h00 completes normally with 8'hAD.
- Back-to-back requests: 10 random writes, each issued one cycle after done -> each shows the correct 3-byte MOSI sequence; CS deasserts between transactions; no byte is lost or duplicated.
